// File: rtl/nibble_word_loader.sv
// Serialises WORD_W-bit words into NIB_W-bit nibbles, LSB first, one per clock; registered outputs, first nibble one cycle after accept.
// in_ready only while idle or on the last-nibble edge (zero-bubble streaming); pause freezes the word in place.
module nibble_word_loader #(
   parameter int WORD_W = 16,
   parameter int NIB_W  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_sel,
   input  logic              pause,
   output logic [NIB_W-1:0]  out_nib,
   output logic              out_sel,
   output logic              out_valid,
   output logic              word_done,
   output logic              busy,
   output logic [CNT_W-1:0]  words_sent
);
   localparam int N_NIB = WORD_W / NIB_W;
   localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  shift_q, shift_d;
   logic               sel_q, sel_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic [NIB_W-1:0]   nib_q, nib_d;
   logic               osel_q, osel_d;
   logic               vld_q, vld_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   sent_q, sent_d;
   logic               last;

   assign last = (cnt_q == IDX_W'(N_NIB - 1));

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      nib_d    = nib_q;
      osel_d   = osel_q;
      vld_d    = 1'b0;
      done_d   = 1'b0;
      sent_d   = sent_q;
      in_ready = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = !pause;
            nib_d    = '0;
            osel_d   = 1'b0;
         end
         SEND: begin
            // Paused edges leave nib/sel holding; only out_valid drops.
            if (!pause) begin
               vld_d   = 1'b1;
               nib_d   = shift_q[NIB_W-1:0];
               osel_d  = sel_q;
               shift_d = shift_q >> NIB_W;
               cnt_d   = cnt_q + 1'b1;
               if (last) begin
                  done_d   = 1'b1;
                  sent_d   = sent_q + 1'b1;
                  in_ready = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst_n) in_ready = 1'b0;

      // A word loaded on the last-nibble edge overrides the return to IDLE.
      if (in_valid && in_ready) begin
         shift_d = in_data;
         sel_d   = in_sel;
         cnt_d   = '0;
         state_d = SEND;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         sel_q   <= 1'b0;
         cnt_q   <= '0;
         nib_q   <= '0;
         osel_q  <= 1'b0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
         sent_q  <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         nib_q   <= nib_d;
         osel_q  <= osel_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
         sent_q  <= sent_d;
      end
   end

   assign out_nib    = nib_q;
   assign out_sel    = osel_q;
   assign out_valid  = vld_q;
   assign word_done  = done_q;
   assign busy       = (state_q == SEND);
   assign words_sent = sent_q;

endmodule

// File: doc/nibble_word_loader.md
Name: nibble_word_loader

Overview:
- Transmit side of the nibble-serial load interface used by the dot-product neuron.
- Accepts whole 16-bit weight or input words over a valid/ready handshake and emits them as 4-bit nibbles, LSB nibble first, one per clock.
- Drives a target-select line: 1 = weights register, 0 = inputs register.
- Sits between the host-side control logic and the neuron's nibble shift registers, so after 4 nibbles the receiver holds the exact word.

Parameters:
- WORD_W, 16, word width in bits; must be a multiple of NIB_W.
- NIB_W, 4, nibble width per transfer; N_NIB = WORD_W/NIB_W (4 by default).
- CNT_W, 8, width of the words-sent counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous, active-high reset (name kept for top-level compatibility).
- in_valid  input  1  word offered.
- in_ready  output  1  loader can accept a word this cycle.
- in_data  input  WORD_W  word to send.
- in_sel  input  1  target of word: 1 = weights, 0 = inputs.
- pause  input  1  freeze transmission; no nibble is emitted while high.
- out_nib  output  NIB_W  nibble to receiver (ui_in[3:0] side).
- out_sel  output  1  target select (uio_in[7] side).
- out_valid  output  1  receiver shift-enable; high only on cycles carrying a real nibble.
- word_done  output  1  one-cycle pulse coincident with the last nibble of a word.
- busy  output  1  word in flight.
- words_sent  output  CNT_W  count of completed words, wraps at 2^CNT_W.

Behaviour:
- Reset (rst_n=1 at posedge): state IDLE, count=0.
  - Outputs cleared: out_nib=0, out_sel=0, out_valid=0, word_done=0, busy=0, words_sent=0.
  - Any partially sent word is aborted and dropped; no further nibbles of it are emitted.
  - in_ready is 0 during the reset cycle.
- FSM states:
  - IDLE: busy=0, in_ready=1, out_valid=0, out_nib=0, out_sel=0.
  - SEND: busy=1.
- Accept: handshake at posedge when in_valid && in_ready.
  - in_data is latched into a WORD_W shift register and in_sel into a select register.
  - count is set to 0 and the state goes to SEND.
- Output registration: all outputs are registered.
  - Nibble k appears on out_nib in the cycle after the edge that issued it.
  - Word accepted at edge T gives nibble 0 (in_data[NIB_W-1:0]) valid from T+1 to T+2.
  - Nibble k = in_data[(k+1)*NIB_W-1 : k*NIB_W]; out_sel = latched in_sel for every nibble of the word.
- SEND with pause=0, each edge:
  - emit the current low nibble with out_valid=1;
  - shift the register right by NIB_W;
  - count++.
- SEND with pause=1: shift register and count hold; next-cycle out_valid=0.
  - out_nib and out_sel hold their last values, so the receiver must ignore them.
- Last nibble (count==N_NIB-1, not paused):
  - word_done=1 together with that nibble;
  - words_sent increments, wrapping modulo 2^CNT_W.
- in_ready in SEND: in_ready = (count==N_NIB-1) && !pause.
  - A word can be accepted on the edge that issues the last nibble.
  - Back-to-back words therefore stream with zero bubble, and out_sel may change between adjacent nibbles.
  - If no new word is accepted on that edge, the state returns to IDLE and out_valid=0 on the following cycle.
- pause while IDLE: in_ready=0; no accept.
- in_valid may drop without transfer; in_data and in_sel are sampled only on the accept edge.
- Word ordering is FIFO by acceptance; there is no reordering between weights and inputs.

Test Plan:
- Single word: after reset, send in_data=0xA5C3, in_sel=1.
  - Required: out_valid high 4 consecutive cycles with out_nib 3,C,5,A and out_sel=1.
  - word_done on the 4th nibble; words_sent=1.
  - A model receiver shifting {nib, reg[15:4]} holds 0xA5C3.
- Back-to-back: hold in_valid with 0x1234 (sel=0) then 0xFFFF (sel=1).
  - Required: 8 contiguous valid nibbles 4,3,2,1,F,F,F,F.
  - out_sel changes 0→1 exactly between nibble 4 and nibble 5; no gap cycle.
- Pause mid-word: send 0x8421 and assert pause for 3 cycles after the 2nd nibble.
  - Required: nibbles 1,2, then out_valid=0 for 3 cycles, then 4,8.
  - word_done only with nibble 8; in_ready stays 0 while paused.
- Reset mid-word: send 0xBEEF and assert rst_n for 1 cycle after the 2nd nibble.
  - Required: all outputs 0 next cycle; nibbles B, E (the remaining two) never appear; words_sent=0.
  - A subsequent word 0x0007 is sent cleanly as 7,0,0,0.
- Counter wrap: stream 256 words.
  - Required: words_sent returns to 0 after the 256th word_done; one word_done per 4 valid nibbles throughout.
- Handshake idle: in_valid=0 for 10 cycles.
  - Required: out_valid=0, busy=0, in_ready=1 throughout; out_nib=0, out_sel=0.
